// File: rtl/lock_pkg.sv
// Shared definitions for the lock blocks: FSM state encoding and default limits.
package lock_pkg;

  typedef enum logic [0:0] {
    StCount  = 1'b0,
    StLocked = 1'b1
  } lock_state_e;

  localparam int unsigned DefMaxErr     = 3;
  localparam int unsigned DefLockCycles = 1024;
  localparam int unsigned TotalMax      = 255;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter that runs to zero; expire marks the cycle whose edge takes it 1 -> 0.
module lockout_timer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = (count_q == W'(1)) && !clear && !load;

endmodule

// File: rtl/attempt_limiter.sv
// Wrong-attempt limiter: counts consecutive failed judgements and enforces a timed lockout.
module attempt_limiter
  import lock_pkg::*;
#(
  parameter int unsigned MAX_ERR     = DefMaxErr,
  parameter int unsigned LOCK_CYCLES = DefLockCycles,
  parameter int unsigned CNT_W       = $clog2(MAX_ERR + 1),
  parameter int unsigned TMR_W       = $clog2(LOCK_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
  input  logic             correct,
  input  logic             admin_clr,
  output logic [CNT_W-1:0] error_count,
  output logic             locked,
  output logic             alarm,
  output logic             rejected,
  output logic [TMR_W-1:0] lock_remaining,
  output logic [7:0]       lockout_total
);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] error_count_q, error_count_d;
  logic             alarm_q, alarm_d;
  logic             rejected_q, rejected_d;
  logic [7:0]       total_q, total_d;
  logic             tmr_load, tmr_clear, tmr_expire;
  int unsigned      err_inc;

  assign err_inc = 32'(error_count_q) + 32'd1;

  always_comb begin
    state_d       = state_q;
    error_count_d = error_count_q;
    alarm_d       = 1'b0;
    rejected_d    = 1'b0;
    total_d       = total_q;
    tmr_load      = 1'b0;
    tmr_clear     = 1'b0;
    // Supervisor clear wins over any attempt and over timer expiry.
    if (admin_clr) begin
      state_d       = StCount;
      error_count_d = '0;
      tmr_clear     = 1'b1;
    end else begin
      unique case (state_q)
        StCount: begin
          if (j) begin
            if (correct) begin
              error_count_d = '0;
            end else if (err_inc >= MAX_ERR) begin
              state_d       = StLocked;
              error_count_d = CNT_W'(MAX_ERR);
              tmr_load      = 1'b1;
              alarm_d       = 1'b1;
              if (32'(total_q) != TotalMax) total_d = total_q + 8'd1;
            end else begin
              error_count_d = CNT_W'(err_inc);
            end
          end
        end
        StLocked: begin
          // An attempt in the expiry cycle still counts as locked: rejected, not counted.
          rejected_d = j;
          if (tmr_expire) begin
            state_d       = StCount;
            error_count_d = '0;
          end
        end
        default: state_d = StCount;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StCount;
      error_count_q <= '0;
      alarm_q       <= 1'b0;
      rejected_q    <= 1'b0;
      total_q       <= '0;
    end else begin
      state_q       <= state_d;
      error_count_q <= error_count_d;
      alarm_q       <= alarm_d;
      rejected_q    <= rejected_d;
      total_q       <= total_d;
    end
  end

  lockout_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .load_val (TMR_W'(LOCK_CYCLES)),
    .count    (lock_remaining),
    .expire   (tmr_expire)
  );

  assign error_count   = error_count_q;
  assign locked        = (state_q == StLocked);
  assign alarm         = alarm_q;
  assign rejected      = rejected_q;
  assign lockout_total = total_q;

endmodule

// File: tb/tb_attempt_limiter.sv
// Directed bench for attempt_limiter: MAX_ERR=3/LOCK_CYCLES=8 instance plus a MAX_ERR=1 instance.
module tb_attempt_limiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic j = 1'b0, correct = 1'b0, admin_clr = 1'b0;
  logic j1 = 1'b0, correct1 = 1'b0, admin_clr1 = 1'b0;

  logic [1:0] ec;
  logic       locked, alarm, rejected;
  logic [3:0] rem;
  logic [7:0] total;

  logic [0:0] ec1;
  logic       locked1, alarm1, rejected1;
  logic [1:0] rem1;
  logic [7:0] total1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  attempt_limiter #(
    .MAX_ERR     (3),
    .LOCK_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .j              (j),
    .correct        (correct),
    .admin_clr      (admin_clr),
    .error_count    (ec),
    .locked         (locked),
    .alarm          (alarm),
    .rejected       (rejected),
    .lock_remaining (rem),
    .lockout_total  (total)
  );

  attempt_limiter #(
    .MAX_ERR     (1),
    .LOCK_CYCLES (2)
  ) dut1 (
    .clk            (clk),
    .rst            (rst),
    .j              (j1),
    .correct        (correct1),
    .admin_clr      (admin_clr1),
    .error_count    (ec1),
    .locked         (locked1),
    .alarm          (alarm1),
    .rejected       (rejected1),
    .lock_remaining (rem1),
    .lockout_total  (total1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic attempt(input logic c);
    j = 1'b1; correct = c;
    tick();
    j = 1'b0; correct = 1'b0;
  endtask

  // Three wrongs then eight idle cycles: one full lockout ending back in COUNT.
  task automatic full_lockout();
    repeat (3) attempt(1'b0);
    repeat (8) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ec, locked, alarm, rejected, rem, total} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ec=%0d lk=%0b al=%0b rj=%0b rem=%0d tot=%0d, want all 0",
               ec, locked, alarm, rejected, rem, total);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_count();
    attempt(1'b0);
    checks++;
    if (ec !== 2'd1 || alarm !== 1'b0) begin
      errors++; $display("FAIL count_wrong1: got ec=%0d al=%0b, want 1 0", ec, alarm);
    end
    // correct without j must be ignored
    correct = 1'b1; tick(); correct = 1'b0;
    checks++;
    if (ec !== 2'd1) begin
      errors++; $display("FAIL count_no_j: got ec=%0d, want 1", ec);
    end
    attempt(1'b0);
    checks++;
    if (ec !== 2'd2 || alarm !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL count_wrong2: got ec=%0d al=%0b lk=%0b, want 2 0 0", ec, alarm, locked);
    end
    attempt(1'b1);
    checks++;
    if (ec !== 2'd0 || alarm !== 1'b0) begin
      errors++; $display("FAIL count_correct: got ec=%0d al=%0b, want 0 0", ec, alarm);
    end
  endtask

  task automatic test_lockout();
    repeat (3) attempt(1'b0);
    checks++;
    if (ec !== 2'd3 || locked !== 1'b1 || alarm !== 1'b1 || rem !== 4'd8 || total !== 8'd1) begin
      errors++;
      $display("FAIL lock_entry: got ec=%0d lk=%0b al=%0b rem=%0d tot=%0d, want 3 1 1 8 1",
               ec, locked, alarm, rem, total);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (rem !== 4'(8 - i) || locked !== 1'b1 || alarm !== 1'b0 || ec !== 2'd3) begin
        errors++;
        $display("FAIL lock_countdown: got rem=%0d lk=%0b al=%0b ec=%0d, want %0d 1 0 3",
                 rem, locked, alarm, ec, 8 - i);
      end
    end
    tick();
    checks++;
    if (rem !== 4'd0 || locked !== 1'b0 || ec !== 2'd0 || total !== 8'd1) begin
      errors++;
      $display("FAIL lock_expire: got rem=%0d lk=%0b ec=%0d tot=%0d, want 0 0 0 1",
               rem, locked, ec, total);
    end
  endtask

  task automatic test_reject();
    repeat (3) attempt(1'b0);
    repeat (2) tick();
    attempt(1'b1);
    checks++;
    if (rejected !== 1'b1 || ec !== 2'd3 || rem !== 4'd5 || locked !== 1'b1) begin
      errors++;
      $display("FAIL reject_pulse: got rj=%0b ec=%0d rem=%0d lk=%0b, want 1 3 5 1",
               rejected, ec, rem, locked);
    end
    tick();
    checks++;
    if (rejected !== 1'b0 || rem !== 4'd4) begin
      errors++; $display("FAIL reject_one_cycle: got rj=%0b rem=%0d, want 0 4", rejected, rem);
    end
    repeat (3) tick();
    checks++;
    if (rem !== 4'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL reject_last_cycle: got rem=%0d lk=%0b, want 1 1", rem, locked);
    end
    // wrong attempt in the expiry cycle: rejected and not counted
    attempt(1'b0);
    checks++;
    if (rejected !== 1'b1 || locked !== 1'b0 || ec !== 2'd0 || rem !== 4'd0 || total !== 8'd2) begin
      errors++;
      $display("FAIL reject_at_expiry: got rj=%0b lk=%0b ec=%0d rem=%0d tot=%0d, want 1 0 0 0 2",
               rejected, locked, ec, rem, total);
    end
    tick();
    checks++;
    if (rejected !== 1'b0 || ec !== 2'd0) begin
      errors++; $display("FAIL reject_after_expiry: got rj=%0b ec=%0d, want 0 0", rejected, ec);
    end
  endtask

  task automatic test_admin();
    repeat (3) attempt(1'b0);
    repeat (4) tick();
    checks++;
    if (rem !== 4'd4) begin
      errors++; $display("FAIL admin_setup: got rem=%0d, want 4", rem);
    end
    admin_clr = 1'b1; j = 1'b1; correct = 1'b0;
    tick();
    admin_clr = 1'b0; j = 1'b0;
    checks++;
    if (locked !== 1'b0 || ec !== 2'd0 || rem !== 4'd0 || rejected !== 1'b0 || total !== 8'd3) begin
      errors++;
      $display("FAIL admin_in_lock: got lk=%0b ec=%0d rem=%0d rj=%0b tot=%0d, want 0 0 0 0 3",
               locked, ec, rem, rejected, total);
    end
    // admin_clr beats the attempt that would otherwise lock
    repeat (2) attempt(1'b0);
    admin_clr = 1'b1; j = 1'b1; correct = 1'b0;
    tick();
    admin_clr = 1'b0; j = 1'b0;
    checks++;
    if (locked !== 1'b0 || ec !== 2'd0 || alarm !== 1'b0 || total !== 8'd3) begin
      errors++;
      $display("FAIL admin_in_count: got lk=%0b ec=%0d al=%0b tot=%0d, want 0 0 0 3",
               locked, ec, alarm, total);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) attempt(1'b0);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ec, locked, alarm, rejected, rem, total} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: got ec=%0d lk=%0b al=%0b rj=%0b rem=%0d tot=%0d, want all 0",
               ec, locked, alarm, rejected, rem, total);
    end
    #1 rst = 1'b0;
    attempt(1'b0);
    checks++;
    if (ec !== 2'd1 || locked !== 1'b0) begin
      errors++; $display("FAIL after_reset: got ec=%0d lk=%0b, want 1 0", ec, locked);
    end
    attempt(1'b1);
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 255; n++) full_lockout();
    checks++;
    if (total !== 8'd255) begin
      errors++; $display("FAIL total_255: got %0d, want 255", total);
    end
    for (int n = 0; n < 4; n++) full_lockout();
    repeat (3) attempt(1'b0);
    checks++;
    if (total !== 8'd255 || locked !== 1'b1 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL total_sat: got tot=%0d lk=%0b al=%0b, want 255 1 1", total, locked, alarm);
    end
    repeat (8) tick();
  endtask

  task automatic test_max_err1();
    j1 = 1'b1; correct1 = 1'b1; tick(); j1 = 1'b0; correct1 = 1'b0;
    checks++;
    if (ec1 !== 1'b0 || locked1 !== 1'b0) begin
      errors++; $display("FAIL m1_correct: got ec=%0d lk=%0b, want 0 0", ec1, locked1);
    end
    j1 = 1'b1; correct1 = 1'b0; tick(); j1 = 1'b0;
    checks++;
    if (ec1 !== 1'b1 || locked1 !== 1'b1 || alarm1 !== 1'b1 || rem1 !== 2'd2 || total1 !== 8'd1) begin
      errors++;
      $display("FAIL m1_lock: got ec=%0d lk=%0b al=%0b rem=%0d tot=%0d, want 1 1 1 2 1",
               ec1, locked1, alarm1, rem1, total1);
    end
    tick();
    checks++;
    if (rem1 !== 2'd1 || alarm1 !== 1'b0 || locked1 !== 1'b1) begin
      errors++; $display("FAIL m1_count: got rem=%0d al=%0b lk=%0b, want 1 0 1", rem1, alarm1, locked1);
    end
    tick();
    checks++;
    if (rem1 !== 2'd0 || locked1 !== 1'b0 || ec1 !== 1'b0) begin
      errors++; $display("FAIL m1_expire: got rem=%0d lk=%0b ec=%0d, want 0 0 0", rem1, locked1, ec1);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_lockout();
    test_reject();
    test_admin();
    test_async_reset();
    test_saturate();
    test_max_err1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/attempt_limiter.md
ATTEMPT_LIMITER -- requirements
Module: attempt_limiter

Interface
REQ-001 Parameter MAX_ERR, default 3, SHALL set the wrong-attempt count that triggers lockout; legal range 1..255.
REQ-002 Parameter LOCK_CYCLES, default 1024, SHALL set the lockout duration in clk cycles; legal range 1..2^24-1.
REQ-003 Parameter CNT_W, default $clog2(MAX_ERR+1), SHALL set the width of error_count.
REQ-004 Parameter TMR_W, default $clog2(LOCK_CYCLES+1), SHALL set the width of lock_remaining.
REQ-005 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 j  input  1  single-cycle judge strobe; an attempt is evaluated in that cycle.
REQ-008 correct  input  1  password-match result; qualified by j only.
REQ-009 admin_clr  input  1  supervisor override; clears the lockout and the error count.
REQ-010 error_count  output  CNT_W  consecutive wrong attempts since the last success, clear or lockout expiry.
REQ-011 locked  output  1  high while the block is in state LOCKED.
REQ-012 alarm  output  1  one-cycle pulse on entry to LOCKED.
REQ-013 rejected  output  1  one-cycle pulse when j arrives while LOCKED.
REQ-014 lock_remaining  output  TMR_W  cycles left in the lockout; 0 when not locked.
REQ-015 lockout_total  output  8  number of lockouts since reset; saturates at 255.

Function
REQ-016 The FSM SHALL have exactly two states: COUNT and LOCKED.
REQ-017 In COUNT, j=1 with correct=1 SHALL set error_count to 0 on the next edge.
REQ-018 In COUNT, j=1 with correct=0 and error_count+1 < MAX_ERR SHALL increment error_count by 1.
REQ-019 In COUNT, j=1 with correct=0 and error_count+1 == MAX_ERR SHALL, on the same edge:
  - move the FSM to LOCKED;
  - set error_count to MAX_ERR;
  - load lock_remaining with LOCK_CYCLES;
  - pulse alarm for 1 cycle;
  - increment lockout_total, saturating at 255.
REQ-020 error_count SHALL never wrap; its maximum value is MAX_ERR.
REQ-021 In LOCKED, lock_remaining SHALL decrement by 1 on each cycle.
REQ-022 When lock_remaining is 1, the next edge SHALL set lock_remaining to 0, set error_count to 0 and move the FSM to COUNT; locked falls in the same cycle.
REQ-023 In LOCKED, j SHALL not change error_count, regardless of correct; rejected SHALL pulse in the cycle after j.
REQ-024 alarm and rejected SHALL be registered outputs, high for exactly 1 cycle per event.
REQ-025 admin_clr=1 in any state SHALL, on the next edge:
  - set the FSM to COUNT;
  - set error_count and lock_remaining to 0;
  - suppress alarm and rejected.
  admin_clr SHALL take priority over a simultaneous j and over timer expiry. lockout_total SHALL be unaffected.
REQ-026 A j arriving in the same cycle as lockout expiry SHALL be treated as a LOCKED-state attempt: it is rejected and not counted.
REQ-027 correct SHALL be ignored when j=0.
REQ-028 With MAX_ERR=1, a single wrong attempt SHALL lock immediately.

Reset
REQ-029 While rst=1, outputs SHALL immediately take these values, independent of clk:
  - FSM = COUNT;
  - error_count = 0, lock_remaining = 0, lockout_total = 0;
  - locked = 0, alarm = 0, rejected = 0.
REQ-030 Reset asserted mid-lockout SHALL abort the lockout; the first j after reset deasserts SHALL be evaluated as in COUNT.

Structure
REQ-031 Package lock_pkg SHALL hold the state enum (COUNT, LOCKED) and the default constants for MAX_ERR and LOCK_CYCLES; other lock blocks share these.
REQ-032 The down-counter SHALL be a sub-module lockout_timer, with these ports:
  - clk, rst;
  - load, clear;
  - load_val, count;
  - expire (pulse on transition 1->0).
REQ-033 attempt_limiter SHALL contain the FSM, the error counter and the output pulse registers only.

Verification
REQ-034 With MAX_ERR=3, LOCK_CYCLES=8: wrong, wrong, correct -> error_count 1, 2, 0; alarm never high.
REQ-035 Three wrong attempts -> error_count=3, locked=1, alarm high for 1 cycle, lock_remaining=8 then counts down to 0; at the 0 edge locked=0 and error_count=0; lockout_total=1.
REQ-036 While locked, apply j with correct=1 -> rejected pulses, error_count stays 3, lockout duration unchanged.
REQ-037 Apply admin_clr together with j/correct=0 at lock_remaining=4 -> next cycle locked=0, error_count=0, lock_remaining=0, no rejected pulse.
REQ-038 Assert rst asynchronously mid-lockout, between edges -> all outputs 0 immediately; after release, one wrong attempt -> error_count=1.
REQ-039 Run 260 lockouts -> lockout_total saturates at 255; also re-run with MAX_ERR=1 -> the first wrong attempt locks.
